// File: rtl/sum_accumulator.sv
// Sums {carry,sum} beats into a group total. Total is valid from the closing-beat edge.
// in_ready is low while a total is held; the handoff cycle is a bubble.
module sum_accumulator #(
  parameter int BITS     = 8,
  parameter int BEATS    = 4,
  parameter int ACC_BITS = 12
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         carry,
  input  logic [BITS-1:0]              sum,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_BITS-1:0]          out_total,
  output logic [$clog2(BEATS+1)-1:0]   out_count,
  output logic                         out_overflow
);

  localparam int CW = $clog2(BEATS + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ACC_BITS-1:0] acc, acc_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic              ovf, ovf_nxt;

  logic [ACC_BITS:0] beat_ext;
  logic [ACC_BITS:0] add_full;
  logic [CW-1:0]     count_inc;
  logic              accept;

  // one spare bit on the adder captures the wrap as the overflow flag
  assign beat_ext  = {{(ACC_BITS-BITS){1'b0}}, carry, sum};
  assign add_full  = {1'b0, acc} + beat_ext;
  assign count_inc = count + 1'b1;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    ovf_nxt   = ovf;
    case (state)
      ACCUM: begin
        if (accept) begin
          acc_nxt   = add_full[ACC_BITS-1:0];
          ovf_nxt   = ovf | add_full[ACC_BITS];
          count_nxt = count_inc;
          if (in_last || (count_inc == CW'(BEATS)))
            state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_nxt   = '0;
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // all outputs decode registered state only
  assign in_ready     = (state == ACCUM);
  assign out_valid    = (state == HOLD);
  assign out_total    = acc;
  assign out_count    = count;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench: three configurations share one stimulus stream; each phase checks one of them.
module tb_sum_accumulator;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       carry = 1'b0;
  logic [7:0] sum = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic        a_in_ready, a_out_valid, a_out_overflow;
  logic [11:0] a_out_total;
  logic [2:0]  a_out_count;
  logic        b_in_ready, b_out_valid, b_out_overflow;
  logic [9:0]  b_out_total;
  logic [2:0]  b_out_count;
  logic        c_in_ready, c_out_valid, c_out_overflow;
  logic [11:0] c_out_total;
  logic [0:0]  c_out_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  sum_accumulator #(.BITS(8), .BEATS(4), .ACC_BITS(12)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .carry(carry), .sum(sum), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_total(a_out_total), .out_count(a_out_count),
    .out_overflow(a_out_overflow));

  sum_accumulator #(.BITS(8), .BEATS(4), .ACC_BITS(10)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .carry(carry), .sum(sum), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_total(b_out_total), .out_count(b_out_count),
    .out_overflow(b_out_overflow));

  sum_accumulator #(.BITS(8), .BEATS(1), .ACC_BITS(12)) u_c (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .carry(carry), .sum(sum), .in_last(in_last), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_total(c_out_total), .out_count(c_out_count),
    .out_overflow(c_out_overflow));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // present one beat for a single edge, then drop in_valid
  task automatic beat(input logic c, input logic [7:0] s, input logic l);
    in_valid = 1'b1;
    carry    = c;
    sum      = s;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    step();
    do_reset();

    // reset state
    check("rst_in_ready",  a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_total",     a_out_total, 0);
    check("rst_count",     a_out_count, 0);
    check("rst_ovf",       a_out_overflow, 0);

    // full group of four
    beat(1'b0, 8'h10, 1'b0);
    check("g1_mid_valid", a_out_valid, 0);
    beat(1'b0, 8'h20, 1'b0);
    beat(1'b1, 8'h05, 1'b0);
    beat(1'b0, 8'hFF, 1'b0);
    check("g1_valid", a_out_valid, 1);
    check("g1_total", a_out_total, 32'h234);
    check("g1_count", a_out_count, 4);
    check("g1_ovf",   a_out_overflow, 0);
    check("g1_in_rdy", a_in_ready, 0);
    step();
    check("g1_hs_valid", a_out_valid, 0);
    check("g1_hs_rdy",   a_in_ready, 1);
    check("g1_hs_clear", a_out_total, 0);

    // early close with in_last
    beat(1'b0, 8'h03, 1'b0);
    beat(1'b0, 8'h04, 1'b1);
    check("g2_valid", a_out_valid, 1);
    check("g2_total", a_out_total, 7);
    check("g2_count", a_out_count, 2);
    step();
    beat(1'b0, 8'h05, 1'b1);
    check("g3_total", a_out_total, 5);
    check("g3_count", a_out_count, 1);
    step();

    // backpressure: total must hold while out_ready is low
    do_reset();
    out_ready = 1'b0;
    beat(1'b0, 8'h01, 1'b0);
    beat(1'b0, 8'h02, 1'b0);
    beat(1'b0, 8'h03, 1'b0);
    beat(1'b0, 8'h04, 1'b0);
    in_valid = 1'b1;
    sum      = 8'h80;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", a_out_valid, 1);
      check("bp_total", a_out_total, 10);
      check("bp_rdy",   a_in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_hs_valid", a_out_valid, 0);
    check("bp_hs_total", a_out_total, 0);
    check("bp_hs_rdy",   a_in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_next_total", a_out_total, 32'h80);
    check("bp_next_count", a_out_count, 1);

    // overflow on 10-bit accumulator
    do_reset();
    beat(1'b1, 8'hFF, 1'b0);
    check("ov_first_ovf", b_out_overflow, 0);
    beat(1'b1, 8'hFF, 1'b0);
    beat(1'b1, 8'hFF, 1'b1);
    check("ov_valid", b_out_valid, 1);
    check("ov_total", b_out_total, 509);
    check("ov_count", b_out_count, 3);
    check("ov_flag",  b_out_overflow, 1);
    step();
    beat(1'b0, 8'h01, 1'b1);
    check("ov2_total", b_out_total, 1);
    check("ov2_flag",  b_out_overflow, 0);
    step();

    // reset mid-group discards the partial total
    do_reset();
    beat(1'b0, 8'h01, 1'b0);
    beat(1'b0, 8'h01, 1'b0);
    check("ab_partial", a_out_count, 2);
    reset = 1'b1;
    #1;
    check("ab_async_count", a_out_count, 0);
    check("ab_async_total", a_out_total, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b0, 8'h01, 1'b0);
    check("ab_valid", a_out_valid, 1);
    check("ab_total", a_out_total, 4);
    check("ab_count", a_out_count, 4);
    step();

    // BEATS=1: every beat closes, one bubble per result
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    carry     = 1'b0;
    in_last   = 1'b0;
    check("b1_rdy0", c_in_ready, 1);
    for (int i = 1; i <= 3; i++) begin
      sum = 8'(i);
      step();
      check("b1_valid", c_out_valid, 1);
      check("b1_total", c_out_total, i);
      check("b1_count", c_out_count, 1);
      check("b1_rdy_lo", c_in_ready, 0);
      step();
      check("b1_rdy_hi", c_in_ready, 1);
      check("b1_idle",   c_out_valid, 0);
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream consumer of a BITS-wide adder stage: takes each {carry, sum} result as one beat over a valid/ready handshake.
- Accumulates up to BEATS beats into a wider running total, then presents the group total on an output valid/ready handshake.
- Intended as the reduction stage behind the adder in multi-word accumulate paths.

Parameters:
- BITS, 8, width of the upstream adder sum (the carry is one extra bit).
- BEATS, 4, maximum beats per group; must be >= 1.
- ACC_BITS, 12, accumulator and total width; must be >= BITS+1.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block can accept a beat this cycle.
- carry  input  1  adder carry-out for this beat.
- sum  input  BITS  adder sum for this beat.
- in_last  input  1  this beat closes the group early; sampled only on accept.
- out_valid  output  1  group total available.
- out_ready  input  1  downstream accepts the total.
- out_total  output  ACC_BITS  group total, modulo 2^ACC_BITS.
- out_count  output  clog2(BEATS+1)  number of beats in the group.
- out_overflow  output  1  group total exceeded 2^ACC_BITS-1 at least once.

Behaviour:
- Reset (async, immediate): state=ACCUM, acc=0, count=0, ovf=0, out_valid=0, in_ready=1, out_total=0, out_count=0, out_overflow=0.
- Beat value = {carry, sum}, i.e. BITS+1 bits, zero-extended to ACC_BITS.
- Accept happens when in_valid && in_ready at a rising edge.
- State ACCUM: in_ready=1, out_valid=0.
  - On accept: acc <= acc + beat (wraps mod 2^ACC_BITS); ovf <= ovf | carry-out of that addition; count <= count+1.
  - If count+1 == BEATS or in_last=1 on the accepted beat: go to HOLD.
  - Otherwise stay in ACCUM.
  - No accept: hold all state.
- State HOLD: in_ready=0, out_valid=1.
  - out_total=acc, out_count=count, out_overflow=ovf, all stable while out_valid && !out_ready.
  - On out_valid && out_ready: acc, count and ovf clear to 0; go to ACCUM.
- Outputs are registered state only; no combinational path from in_* to out_*, or from out_ready to in_ready.
- Latency: the closing beat is accepted at edge k; out_valid is high from edge k to the handoff edge.
- Throughput: the handoff cycle is a bubble, so in_ready=1 no earlier than the cycle after the handoff edge. Worst-case rate is BEATS beats per BEATS+1 cycles with out_ready=1.
- Beat fields (carry, sum, in_last) are ignored when not accepted, including while in_valid=0 or in HOLD.
- A single beat with in_last=1 from an empty accumulator produces out_count=1 with that beat's value.
- BEATS=1: every accepted beat closes its group.
- out_overflow is sticky within a group only; it clears on handoff.
- Reset asserted mid-group or during HOLD discards the partial or pending total immediately. No output handshake is completed for it.

Test Plan:
- Reset, then 4 beats {0,0x10},{0,0x20},{1,0x05},{0,0xFF} with out_ready=1 -> after beat 4 accept, out_valid=1, out_total=0x234, out_count=4, out_overflow=0; in_ready=0 that cycle.
- 2 beats {0,0x03},{0,0x04}, second with in_last=1 -> out_total=7, out_count=2; next group starts from acc=0.
- Closing group reached, out_ready=0 for 5 cycles with in_valid=1 held -> out_valid stays 1 with out_total stable; in_ready=0; no beat accepted until one cycle after out_ready=1 handoff.
- ACC_BITS=10, 3 beats {1,0xFF} with last on the third -> out_total=509 (1533 mod 1024), out_overflow=1; following group {0,0x01},last -> out_overflow=0, out_total=1.
- Assert reset after 2 of 4 beats accepted, release, then send 4 beats of {0,0x01} -> out_total=4, out_count=4 (no residue from the aborted group).
- BEATS=1, continuous in_valid with out_ready=1, beats 1,2,3 -> out_total 1,2,3 each with out_count=1; in_ready alternates 1,0 (one bubble per result).
